incubator_plant: RTL and testbench
==================================

Name: incubator_plant

Overview:
- Closed-loop thermal plant model: the environment side of the incubator controller's interface.
- Consumes the controller's actuator outputs (cooler, fan, heater) and produces the signed 8-bit temperature the controller samples.
- Used in system-level benches and on-board demo builds. Adds a test load port, a conflict fault flag and an out-of-range alarm.

Parameters:
- TICK_DIV, 4: clock cycles per thermal update step (>=1).
- INIT_TEMP, 25: temperature after reset (signed).
- AMBIENT, 22: idle drift target (signed).
- HEAT_STEP, 2: degrees added per step while heating.
- COOL_STEP, 1: base degrees removed per step while cooling.
- TMIN, -40: lower saturation limit.
- TMAX, 100: upper saturation limit.
- ALARM_HI, 50: alarm threshold; a temperature strictly above this is out of range.
- ALARM_LO, 5: alarm threshold; a temperature strictly below this is out of range.
- ALARM_STEPS, 3: consecutive out-of-range steps required to raise alarm.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cooler  in  1  cooling actuator enable.
- heater  in  1  heating actuator enable.
- fan  in  4  fan speed (legal values 0, 4, 6, 8; any value is accepted).
- load  in  1  synchronous overwrite of temperature.
- load_value  in  8 signed  value written on load.
- temperature  out  8 signed  registered plant temperature.
- step_pulse  out  1  one-cycle pulse in the cycle temperature updates from a step.
- fault  out  1  sticky: heater and cooler were both high at a step.
- alarm  out  1  temperature out of range for ALARM_STEPS consecutive steps.

Behaviour:
- Reset (rst=0, async): temperature=INIT_TEMP, prescaler=0, step_pulse=0, fault=0, alarm=0, alarm counter=0.
- Prescaler counts 0..TICK_DIV-1 and wraps. A step fires on the edge where the count is TICK_DIV-1. The first step after reset therefore lands TICK_DIV cycles later.
- Step delta, computed in 10-bit signed arithmetic:
  - heater=1, cooler=0: +HEAT_STEP.
  - cooler=1, heater=0: -(COOL_STEP + (fan>>1)). fan 0/4/6/8 gives extra 0/2/3/4.
  - heater=1, cooler=1: delta 0; fault set (sticky until reset).
  - Neither: drift 1 toward AMBIENT. -1 if temp>AMBIENT, +1 if temp<AMBIENT, 0 if equal. fan is ignored.
- Result is clamped to [TMIN, TMAX] before registering. No wrap-around is ever permitted.
- step_pulse=1 in the cycle following a step edge, aligned with the new temperature value.
- Load (load=1): on that edge, temperature = load_value clamped to [TMIN, TMAX].
  - Prescaler resets to 0; alarm counter and alarm clear.
  - Any coincident step is discarded: no step_pulse, and fault is not updated.
  - Load held high holds prescaler at 0, so no steps fire.
- Alarm counter: on each step, if the new temperature is >ALARM_HI or <ALARM_LO, increment (saturating at ALARM_STEPS); otherwise clear it to 0.
  - alarm = (counter == ALARM_STEPS). It is registered and updates in the same cycle as temperature.
- Inputs are sampled only at the step edge. Actuator changes between steps have no effect.
- Reset asserted mid-operation returns every register to its reset value immediately, regardless of clk.

Test Plan:
- Reset, heater=1, others 0, defaults -> temperature 25, then 27 at cycle 4 (step_pulse high), then 29 at cycle 8; fault=0.
- From 25: cooler=1, fan=8 -> 20 after one step, 15 after two. Same with fan=0 -> 24, then 23.
- All actuators off from 25 -> 24, 23, 22, then holds 22 with step_pulse still pulsing every 4 cycles.
- load=1, load_value=99, then heater=1 -> 100 after step 1; stays 100 after step 2 (saturation). load_value=-128 -> temperature -40.
- heater=1 and cooler=1 at a step -> temperature unchanged, fault=1. Fault stays 1 after inputs clear; only rst clears it.
- Load 60, heater=1 -> 62, 64, 66 with alarm=1 at the third step. Then load 30 -> alarm=0 in the same cycle. Assert rst mid-count -> temperature=25 asynchronously.

Source files
------------

// File: rtl/incubator_plant_if.sv
// Actuator/plant bundle between the incubator controller and the thermal
// plant model.
//   master : controller side, drives the actuators and the test load port
//   slave  : plant side, returns temperature, step_pulse, fault and alarm
// Signals:
//   cooler, heater      actuator enables
//   fan[3:0]            fan speed (0/4/6/8 expected, any value accepted)
//   load, load_value    synchronous temperature overwrite
//   temperature         signed plant temperature (registered)
//   step_pulse          one-cycle pulse with each thermal step
//   fault               sticky heater/cooler conflict flag
//   alarm               sustained out-of-range flag
interface incubator_plant_if;
  logic              cooler;
  logic              heater;
  logic [3:0]        fan;
  logic              load;
  logic signed [7:0] load_value;
  logic signed [7:0] temperature;
  logic              step_pulse;
  logic              fault;
  logic              alarm;

  modport master (
    output cooler, heater, fan, load, load_value,
    input  temperature, step_pulse, fault, alarm
  );

  modport slave (
    input  cooler, heater, fan, load, load_value,
    output temperature, step_pulse, fault, alarm
  );
endinterface

// File: rtl/incubator_plant.sv
// Closed-loop thermal plant model: the environment side of the incubator
// controller. Every TICK_DIV cycles the temperature moves according to the
// sampled actuators, saturating at [TMIN, TMAX]. A load port overwrites the
// temperature for tests, a sticky fault records heater/cooler conflicts and
// an alarm flags ALARM_STEPS consecutive out-of-range steps.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   plant  incubator_plant_if.slave (actuators in, temperature/flags out)
module incubator_plant #(
  parameter int TICK_DIV    = 4,
  parameter int INIT_TEMP   = 25,
  parameter int AMBIENT     = 22,
  parameter int HEAT_STEP   = 2,
  parameter int COOL_STEP   = 1,
  parameter int TMIN        = -40,
  parameter int TMAX        = 100,
  parameter int ALARM_HI    = 50,
  parameter int ALARM_LO    = 5,
  parameter int ALARM_STEPS = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  incubator_plant_if.slave  plant
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = (ALARM_STEPS > 1) ? $clog2(ALARM_STEPS + 1) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] CNT_MAX  = AW'(ALARM_STEPS);

  // Step arithmetic is 10-bit signed so temp +/- delta can never wrap
  // before the clamp.
  localparam logic signed [9:0] TMIN10 = 10'(TMIN);
  localparam logic signed [9:0] TMAX10 = 10'(TMAX);
  localparam logic signed [9:0] AMB10  = 10'(AMBIENT);
  localparam logic signed [9:0] HEAT10 = 10'(HEAT_STEP);
  localparam logic signed [9:0] COOL10 = 10'(COOL_STEP);

  localparam logic signed [7:0] INIT8 = 8'(INIT_TEMP);
  localparam logic signed [7:0] HI8   = 8'(ALARM_HI);
  localparam logic signed [7:0] LO8   = 8'(ALARM_LO);

  function automatic logic signed [7:0] clamp_temp(input logic signed [9:0] v);
    logic signed [7:0] r;
    if (v < TMIN10)      r = TMIN10[7:0];
    else if (v > TMAX10) r = TMAX10[7:0];
    else                 r = v[7:0];
    return r;
  endfunction

  logic [PW-1:0]     pre_q, pre_d;
  logic signed [7:0] temp_q, temp_d;
  logic              pulse_q, pulse_d;
  logic              fault_q, fault_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              alarm_q, alarm_d;

  logic              step_fire;
  logic [3:0]        fan_half;
  logic signed [9:0] temp_ext;
  logic signed [9:0] load_ext;
  logic signed [9:0] cool_mag;
  logic signed [9:0] delta;
  logic signed [7:0] step_temp;
  logic signed [7:0] load_temp;
  logic              step_oor;

  assign step_fire = (pre_q == PRE_LAST);

  // Thermal step datapath
  always_comb begin
    fan_half = plant.fan >> 1;
    temp_ext = $signed({{2{temp_q[7]}}, temp_q});
    load_ext = $signed({{2{plant.load_value[7]}}, plant.load_value});
    cool_mag = COOL10 + $signed({6'b0, fan_half});
    delta    = '0;
    case ({plant.heater, plant.cooler})
      2'b10:   delta = HEAT10;
      2'b01:   delta = -cool_mag;
      2'b11:   delta = '0;
      default: begin
        // Idle: drift one degree toward ambient, fan has no effect
        if (temp_ext > AMB10)      delta = -10'sd1;
        else if (temp_ext < AMB10) delta = 10'sd1;
        else                       delta = '0;
      end
    endcase
    step_temp = clamp_temp(temp_ext + delta);
    load_temp = clamp_temp(load_ext);
    step_oor  = (step_temp > HI8) || (step_temp < LO8);
  end

  // Next-state: load wins over a coincident step and discards it entirely
  always_comb begin
    pre_d   = pre_q;
    temp_d  = temp_q;
    pulse_d = 1'b0;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    if (plant.load) begin
      pre_d  = '0;
      temp_d = load_temp;
      cnt_d  = '0;
    end else if (step_fire) begin
      pre_d   = '0;
      temp_d  = step_temp;
      pulse_d = 1'b1;
      if (plant.heater && plant.cooler) fault_d = 1'b1;
      if (!step_oor)            cnt_d = '0;
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + AW'(1);
    end else begin
      pre_d = pre_q + PW'(1);
    end
    alarm_d = (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q   <= '0;
      temp_q  <= INIT8;
      pulse_q <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
      alarm_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      temp_q  <= temp_d;
      pulse_q <= pulse_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
      alarm_q <= alarm_d;
    end
  end

  assign plant.temperature = temp_q;
  assign plant.step_pulse  = pulse_q;
  assign plant.fault       = fault_q;
  assign plant.alarm       = alarm_q;

endmodule

// File: tb/tb_incubator_plant.sv
// Directed bench for incubator_plant (default parameters).
module tb_incubator_plant;

  localparam int TICK = 4;

  logic clk;
  logic rst_n;
  incubator_plant_if pif ();

  incubator_plant dut (
    .clk   (clk),
    .rst_n (rst_n),
    .plant (pif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    bit is_load;
    int val;
    bit heat;
    bit cool;
    int fan;
    int exp_t;
    bit exp_f;
    bit exp_a;
  } vec_t;

  vec_t vq[$];

  task automatic set_act(input bit h, input bit c, input int f);
    pif.heater = h;
    pif.cooler = c;
    pif.fan    = 4'(f);
  endtask

  // Waits for the next step_pulse (bounded), reports cycles taken.
  task automatic wait_step(output int n);
    n = 0;
    for (int k = 0; k < 2 * TICK; k++) begin
      @(negedge clk);
      n++;
      if (pif.step_pulse) break;
    end
  endtask

  int n;
  int any_pulse;

  initial begin
    rst_n = 1'b0;
    set_act(0, 0, 0);
    pif.load       = 1'b0;
    pif.load_value = '0;

    // L=load vector, S=step vector
    vq.push_back('{1,   25, 0, 0, 0,  25, 0, 0});
    vq.push_back('{0,    0, 1, 0, 0,  27, 0, 0});
    vq.push_back('{0,    0, 1, 0, 0,  29, 0, 0});
    vq.push_back('{1,   25, 0, 0, 0,  25, 0, 0});
    vq.push_back('{0,    0, 0, 1, 8,  20, 0, 0});
    vq.push_back('{0,    0, 0, 1, 8,  15, 0, 0});
    vq.push_back('{1,   25, 0, 0, 0,  25, 0, 0});
    vq.push_back('{0,    0, 0, 1, 0,  24, 0, 0});
    vq.push_back('{0,    0, 0, 1, 0,  23, 0, 0});
    vq.push_back('{1,   25, 0, 0, 0,  25, 0, 0});
    vq.push_back('{0,    0, 0, 0, 0,  24, 0, 0});
    vq.push_back('{0,    0, 0, 0, 8,  23, 0, 0});
    vq.push_back('{0,    0, 0, 0, 0,  22, 0, 0});
    vq.push_back('{0,    0, 0, 0, 0,  22, 0, 0});
    vq.push_back('{1,   99, 0, 0, 0,  99, 0, 0});
    vq.push_back('{0,    0, 1, 0, 0, 100, 0, 0});
    vq.push_back('{0,    0, 1, 0, 0, 100, 0, 0});
    vq.push_back('{1, -128, 0, 0, 0, -40, 0, 0});
    vq.push_back('{0,    0, 0, 1, 8, -40, 0, 0});
    vq.push_back('{0,    0, 0, 1, 8, -40, 0, 0});
    vq.push_back('{1,   60, 0, 0, 0,  60, 0, 0});
    vq.push_back('{0,    0, 1, 0, 0,  62, 0, 0});
    vq.push_back('{0,    0, 1, 0, 0,  64, 0, 0});
    vq.push_back('{0,    0, 1, 0, 0,  66, 0, 1});
    vq.push_back('{0,    0, 1, 0, 0,  68, 0, 1});
    vq.push_back('{1,   30, 0, 0, 0,  30, 0, 0});
    vq.push_back('{0,    0, 1, 1, 0,  30, 1, 0});
    vq.push_back('{0,    0, 0, 0, 0,  29, 1, 0});
    vq.push_back('{1,   25, 0, 0, 0,  25, 1, 0});

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_temp",  int'(pif.temperature), 25);
    check("rst_pulse", int'(pif.step_pulse), 0);
    check("rst_fault", int'(pif.fault), 0);
    check("rst_alarm", int'(pif.alarm), 0);
    rst_n = 1'b1;

    // Load coinciding with a conflicting step: step and fault discarded
    set_act(1, 1, 0);
    repeat (TICK - 1) @(negedge clk);
    check("pre_coinc_pulse", int'(pif.step_pulse), 0);
    pif.load       = 1'b1;
    pif.load_value = 8'sd40;
    @(negedge clk);
    pif.load = 1'b0;
    set_act(0, 0, 0);
    check("coinc_temp",  int'(pif.temperature), 40);
    check("coinc_pulse", int'(pif.step_pulse), 0);
    check("coinc_fault", int'(pif.fault), 0);

    foreach (vq[i]) begin
      vec_t v;
      v = vq[i];
      set_act(v.heat, v.cool, v.fan);
      if (v.is_load) begin
        pif.load       = 1'b1;
        pif.load_value = 8'(v.val);
        @(negedge clk);
        pif.load = 1'b0;
        check($sformatf("v%0d_load_pulse", i), int'(pif.step_pulse), 0);
      end else begin
        wait_step(n);
        check($sformatf("v%0d_latency", i), n, TICK);
      end
      check($sformatf("v%0d_temp", i),  int'(pif.temperature), v.exp_t);
      check($sformatf("v%0d_fault", i), int'(pif.fault), int'(v.exp_f));
      check($sformatf("v%0d_alarm", i), int'(pif.alarm), int'(v.exp_a));
    end

    // Load held high: prescaler pinned, no steps fire
    set_act(1, 0, 0);
    pif.load       = 1'b1;
    pif.load_value = 8'sd10;
    any_pulse = 0;
    for (int k = 0; k < 3 * TICK; k++) begin
      @(negedge clk);
      if (pif.step_pulse) any_pulse = 1;
    end
    pif.load = 1'b0;
    set_act(0, 0, 0);
    check("hold_no_pulse", any_pulse, 0);
    check("hold_temp", int'(pif.temperature), 10);
    wait_step(n);
    check("hold_latency", n, TICK);
    check("hold_step_temp", int'(pif.temperature), 11);

    // Asynchronous reset between clock edges
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_temp",  int'(pif.temperature), 25);
    check("async_fault", int'(pif.fault), 0);
    check("async_alarm", int'(pif.alarm), 0);
    check("async_pulse", int'(pif.step_pulse), 0);
    @(negedge clk);
    rst_n = 1'b1;
    set_act(1, 0, 0);
    wait_step(n);
    check("post_rst_latency", n, TICK);
    check("post_rst_temp", int'(pif.temperature), 27);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
